// File: rtl/game_ctrl_pkg.sv
// Shared encodings for the game controller and its datapath: state codes,
// move codes and the piece spawn column.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_GEN      = 3'd0,
        ST_MOVE     = 3'd1,
        ST_LAND     = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_NEWBOARD = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MV_NONE   = 2'd0,
        MV_LEFT   = 2'd1,
        MV_RIGHT  = 2'd2,
        MV_ROTATE = 2'd3
    } move_t;

    localparam logic [4:0] SPAWN_LOC  = 5'd2;
    localparam logic [7:0] PIECES_MAX = 8'd255;

    // Anything in row 7 after a clear means the stack reached the top.
    function automatic logic top_row_busy(input logic [31:0] board);
        return board[31:28] != 4'd0;
    endfunction

endpackage

// File: rtl/game_ctrl_btn_req.sv
// Button front end: rising-edge detection, sticky move requests and
// rotate > left > right arbitration (left+right together cancel out).
module btn_req
    import game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rotate,
    input  logic       btn_start,
    input  logic       capture_en,
    input  logic       grant_en,
    input  logic       flush,
    output logic [1:0] move,
    output logic       start_rise
);

    // bit 0 left, 1 right, 2 rotate, 3 start
    logic [3:0] btn_vec;
    logic [3:0] rise;
    logic [2:0] req_reg;
    logic [2:0] req_next;
    logic [2:0] consume;

    assign btn_vec = {btn_start, btn_rotate, btn_right, btn_left};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            logic prev_reg;
            always_ff @(posedge clk) begin
                if (srst) prev_reg <= 1'b0;
                else      prev_reg <= btn_vec[gi];
            end
            assign rise[gi] = btn_vec[gi] & ~prev_reg;
        end
    endgenerate

    assign start_rise = rise[3];

    always_comb begin
        move    = MV_NONE;
        consume = 3'b000;
        if (grant_en) begin
            if (req_reg[2]) begin
                move    = MV_ROTATE;
                consume = 3'b100;
            end else if (req_reg[0] && req_reg[1]) begin
                consume = 3'b011;
            end else if (req_reg[0]) begin
                move    = MV_LEFT;
                consume = 3'b001;
            end else if (req_reg[1]) begin
                move    = MV_RIGHT;
                consume = 3'b010;
            end
        end
        // a fresh edge in the same cycle as a grant re-arms the request
        req_next = flush ? 3'b000
                         : ((req_reg & ~consume) | (rise[2:0] & {3{capture_en}}));
    end

    always_ff @(posedge clk) begin
        if (srst) req_reg <= 3'b000;
        else      req_reg <= req_next;
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing FSM: spawns pieces, paces player moves with a gap counter,
// counts landings and detects game over; feeds registered state to the datapath.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int MOVE_GAP = 4
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rotate,
    input  logic        btn_start,
    input  logic        touched,
    input  logic        error_out,
    input  logic [31:0] board_out,
    input  logic [4:0]  location_out,
    input  logic [1:0]  rotation_out,
    input  logic [1:0]  curr_piece_out,
    output logic [2:0]  state,
    output logic [2:0]  old_state,
    output logic [1:0]  move,
    output logic [31:0] board_in,
    output logic [4:0]  location_in,
    output logic [1:0]  rotation_in,
    output logic [1:0]  curr_piece_in,
    output logic [7:0]  pieces_placed,
    output logic        game_over
);

    localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MOVE_GAP - 1);

    state_t state_reg, state_next, old_state_reg;
    logic [31:0]      board_reg, board_next;
    logic [4:0]       loc_reg, loc_next;
    logic [1:0]       rot_reg, rot_next;
    logic [1:0]       piece_reg, piece_next;
    logic [7:0]       pieces_reg, pieces_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [1:0]       req_move;
    logic             start_rise;
    logic             in_move;

    assign in_move = (state_reg == ST_MOVE);

    btn_req u_btn_req (
        .clk        (clka),
        .srst       (restart),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_rotate (btn_rotate),
        .btn_start  (btn_start),
        .capture_en (in_move),
        .grant_en   (in_move && (gap_reg == '0)),
        .flush      ((state_reg == ST_GEN) || (in_move && touched)),
        .move       (req_move),
        .start_rise (start_rise)
    );

    always_comb begin
        state_next  = state_reg;
        board_next  = board_reg;
        loc_next    = loc_reg;
        rot_next    = rot_reg;
        piece_next  = piece_reg;
        pieces_next = pieces_reg;
        gap_next    = gap_reg;
        case (state_reg)
            ST_NEWBOARD: begin
                board_next  = '0;
                loc_next    = SPAWN_LOC;
                rot_next    = '0;
                piece_next  = '0;
                pieces_next = '0;
                state_next  = ST_GEN;
            end
            ST_GEN: begin
                piece_next = curr_piece_out;
                loc_next   = SPAWN_LOC;
                rot_next   = '0;
                gap_next   = '0;
                state_next = ST_MOVE;
            end
            ST_MOVE: begin
                loc_next   = location_out;
                rot_next   = rotation_out;
                board_next = board_out;
                if (req_move != MV_NONE) gap_next = GAP_LOAD;
                else if (gap_reg != '0)  gap_next = gap_reg - GAP_W'(1);
                if (touched) state_next = ST_LAND;
            end
            ST_LAND: begin
                board_next  = board_out;
                pieces_next = (pieces_reg == PIECES_MAX) ? pieces_reg : pieces_reg + 8'd1;
                state_next  = ST_CLEAR;
            end
            ST_CLEAR: begin
                board_next = board_out;
                state_next = (error_out || top_row_busy(board_out)) ? ST_GAMEOVER : ST_GEN;
            end
            ST_GAMEOVER: begin
                if (start_rise) state_next = ST_NEWBOARD;
            end
            default: state_next = ST_NEWBOARD;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_reg     <= ST_NEWBOARD;
            old_state_reg <= ST_NEWBOARD;
            board_reg     <= '0;
            loc_reg       <= '0;
            rot_reg       <= '0;
            piece_reg     <= '0;
            pieces_reg    <= '0;
            gap_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            old_state_reg <= state_reg;
            board_reg     <= board_next;
            loc_reg       <= loc_next;
            rot_reg       <= rot_next;
            piece_reg     <= piece_next;
            pieces_reg    <= pieces_next;
            gap_reg       <= gap_next;
        end
    end

    assign state         = state_reg;
    assign old_state     = old_state_reg;
    assign move          = req_move;
    assign board_in      = board_reg;
    assign location_in   = loc_reg;
    assign rotation_in   = rot_reg;
    assign curr_piece_in = piece_reg;
    assign pieces_placed = pieces_reg;
    assign game_over     = (state_reg == ST_GAMEOVER);

endmodule
